// File: rtl/ins_dispatcher.sv
// ins_dispatcher: in-order instruction dispatcher between the host instruction
// port and the load/calc/save engines. A one-entry head register feeds
// registered engine valids. A per-buffer scoreboard enforces the
// load -> calc -> save ordering on ping-pong buffers.
// Optional feature: define INS_DISPATCH_PERF_EN to add the stall_cycles and
// issue_count performance counters.
module ins_dispatcher #(
  parameter int NUM_BUF  = 2,
  parameter int BUF_W    = 1,
  parameter int LD_CNT_W = 4
) (
  input  logic                core_clk,
  input  logic                rst_n,
  input  logic                ins_valid,
  output logic                ins_ready,
  input  logic [63:0]         ins,
  output logic [55:0]         conf,
  output logic                conf_upd,
  output logic                ld_valid,
  input  logic                ld_ready,
  output logic                cl_valid,
  input  logic                cl_ready,
  output logic                sv_valid,
  input  logic                sv_ready,
  output logic [55:0]         eng_ins,
  output logic [BUF_W-1:0]    eng_buf,
  input  logic                ld_done,
  input  logic                cl_done,
  input  logic                sv_done,
  input  logic [BUF_W-1:0]    ld_done_buf,
  input  logic [BUF_W-1:0]    cl_done_buf,
  input  logic [BUF_W-1:0]    sv_done_buf,
  output logic                working,
  output logic                err_illegal
`ifdef INS_DISPATCH_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         issue_count
`endif
);

  localparam logic [3:0]          OP_CONF = 4'd0;
  localparam logic [3:0]          OP_LOAD = 4'd1;
  localparam logic [3:0]          OP_CALC = 4'd2;
  localparam logic [3:0]          OP_SAVE = 4'd3;
  localparam logic [LD_CNT_W-1:0] CNT_ONE = LD_CNT_W'(1);

  logic                head_valid;
  logic [3:0]          head_op;
  logic [BUF_W-1:0]    head_buf;
  logic [55:0]         head_payload;

  logic [LD_CNT_W-1:0] ld_cnt [NUM_BUF];
  logic [NUM_BUF-1:0]  cl_busy;
  logic [NUM_BUF-1:0]  sv_busy;

  logic                any_ld_cnt;
  logic                all_idle;
  logic                buf_ld_zero;
  logic                buf_ld_full;
  logic                buf_busy;
  logic                any_valid;
  logic                hs_ld;
  logic                hs_cl;
  logic                hs_sv;
  logic                hs_any;
  logic                raise_ld;
  logic                raise_cl;
  logic                raise_sv;
  logic                raise_any;
  logic                conf_issue;
  logic                illegal_drop;
  logic                head_issue;
  logic                ins_accept;

  logic [NUM_BUF-1:0]  ld_inc;
  logic [NUM_BUF-1:0]  ld_dec;
  logic [NUM_BUF-1:0]  cl_set;
  logic [NUM_BUF-1:0]  cl_clr;
  logic [NUM_BUF-1:0]  sv_set;
  logic [NUM_BUF-1:0]  sv_clr;

  // Detect any buffer that still has loads in flight.
  always_comb begin
    any_ld_cnt = 1'b0;
    for (int b = 0; b < NUM_BUF; b++) begin
      if (ld_cnt[b] != '0) any_ld_cnt = 1'b1;
    end
  end

  assign all_idle    = !any_ld_cnt && (cl_busy == '0) && (sv_busy == '0);
  assign buf_ld_zero = (ld_cnt[head_buf] == '0);
  assign buf_ld_full = &ld_cnt[head_buf];
  assign buf_busy    = cl_busy[head_buf] | sv_busy[head_buf];

  assign any_valid = ld_valid | cl_valid | sv_valid;
  assign hs_ld     = ld_valid & ld_ready;
  assign hs_cl     = cl_valid & cl_ready;
  assign hs_sv     = sv_valid & sv_ready;
  assign hs_any    = hs_ld | hs_cl | hs_sv;

  // Decide what the head may do this cycle; engine ops only raise a valid
  // when no other valid is outstanding, which keeps strict program order.
  always_comb begin
    raise_ld     = 1'b0;
    raise_cl     = 1'b0;
    raise_sv     = 1'b0;
    conf_issue   = 1'b0;
    illegal_drop = 1'b0;
    if (head_valid && !any_valid) begin
      case (head_op)
        OP_CONF: conf_issue = all_idle;
        OP_LOAD: raise_ld   = !buf_busy && !buf_ld_full;
        OP_CALC: raise_cl   = buf_ld_zero && !buf_busy;
        OP_SAVE: raise_sv   = buf_ld_zero && !buf_busy;
        default: illegal_drop = 1'b1;
      endcase
    end
  end

  assign raise_any  = raise_ld | raise_cl | raise_sv;
  // An engine op leaves the head on its handshake; CONF and illegal ops in one cycle.
  assign head_issue = hs_any | conf_issue | illegal_drop;
  // Gated by rst_n so that every output reads 0 while reset is held.
  assign ins_ready  = rst_n & (!head_valid | head_issue);
  assign ins_accept = ins_valid & ins_ready;

  // Head register: load on acceptance, empty once the held instruction issues.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid   <= 1'b0;
      head_op      <= '0;
      head_buf     <= '0;
      head_payload <= '0;
    end else if (ins_accept) begin
      head_valid   <= 1'b1;
      head_op      <= ins[63:60];
      head_buf     <= ins[56 +: BUF_W];
      head_payload <= ins[55:0];
    end else if (head_issue) begin
      head_valid   <= 1'b0;
    end
  end

  // Registered engine valids: raised from the head, held until the handshake.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_valid <= 1'b0;
      cl_valid <= 1'b0;
      sv_valid <= 1'b0;
      eng_ins  <= '0;
      eng_buf  <= '0;
    end else begin
      if (raise_ld) ld_valid <= 1'b1;
      else if (hs_ld) ld_valid <= 1'b0;
      if (raise_cl) cl_valid <= 1'b1;
      else if (hs_cl) cl_valid <= 1'b0;
      if (raise_sv) sv_valid <= 1'b1;
      else if (hs_sv) sv_valid <= 1'b0;
      if (raise_any) begin
        eng_ins <= head_payload;
        eng_buf <= head_buf;
      end
    end
  end

  // Per-buffer scoreboard events; completions on an idle buffer are ignored.
  always_comb begin
    ld_inc = '0;
    ld_dec = '0;
    cl_set = '0;
    cl_clr = '0;
    sv_set = '0;
    sv_clr = '0;
    for (int b = 0; b < NUM_BUF; b++) begin
      ld_inc[b] = hs_ld && (eng_buf == BUF_W'(b));
      ld_dec[b] = ld_done && (ld_done_buf == BUF_W'(b)) && (ld_cnt[b] != '0);
      cl_set[b] = hs_cl && (eng_buf == BUF_W'(b));
      cl_clr[b] = cl_done && (cl_done_buf == BUF_W'(b));
      sv_set[b] = hs_sv && (eng_buf == BUF_W'(b));
      sv_clr[b] = sv_done && (sv_done_buf == BUF_W'(b));
    end
  end

  // Scoreboard state: a same-cycle issue and done leave the counter unchanged,
  // and busy bits are cleared by done before being set by issue.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BUF; b++) ld_cnt[b] <= '0;
      cl_busy <= '0;
      sv_busy <= '0;
    end else begin
      for (int b = 0; b < NUM_BUF; b++) begin
        if (ld_inc[b] && !ld_dec[b]) ld_cnt[b] <= ld_cnt[b] + CNT_ONE;
        else if (ld_dec[b] && !ld_inc[b]) ld_cnt[b] <= ld_cnt[b] - CNT_ONE;
      end
      cl_busy <= (cl_busy & ~cl_clr) | cl_set;
      sv_busy <= (sv_busy & ~sv_clr) | sv_set;
    end
  end

  // Layer configuration register with a one-cycle update pulse.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      conf     <= '0;
      conf_upd <= 1'b0;
    end else begin
      conf_upd <= conf_issue;
      if (conf_issue) conf <= head_payload;
    end
  end

  // Sticky flag for opcodes outside CONF/LOAD/CALC/SAVE.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) err_illegal <= 1'b0;
    else if (illegal_drop) err_illegal <= 1'b1;
  end

  assign working = head_valid | any_ld_cnt | (|cl_busy) | (|sv_busy);

`ifdef INS_DISPATCH_PERF_EN
  // Saturating counters of head stall cycles and issued instructions.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      if (head_valid && !head_issue && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
      if ((hs_any || conf_issue) && !(&issue_count)) issue_count <= issue_count + 32'd1;
    end
  end
`endif

endmodule
